key_schedule_gen: RTL and testbench
===================================

KEY_SCHEDULE_GEN -- requirements
Module: key_schedule_gen

Interface
REQ-001 SHALL have parameter MAX_KEY_BITS, default 256; largest supported key size (128, 192 or 256); key_in width.
REQ-002 SHALL have parameter RKEY_STORE, default 1; 1 = round-key buffer and read port present, 0 = stream only (rd_data tied 0).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  expansion request, sampled in IDLE only.
REQ-006 SHALL have port key_size  input  2  00=128, 01=192, 10=256, 11=illegal; sampled with start.
REQ-007 SHALL have port key_in  input  MAX_KEY_BITS  cipher key, left-aligned (word 0 at MSBs); unused LSBs ignored.
REQ-008 SHALL have port busy  output  1  expansion in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, schedule complete.
REQ-010 SHALL have port err  output  1  one-cycle pulse, illegal/unsupported key_size on start.
REQ-011 SHALL have port rk_valid  output  1  one-cycle pulse per completed round key.
REQ-012 SHALL have port rk_idx  output  4  round-key index 0..Nr of rk_out.
REQ-013 SHALL have port rk_out  output  128  round key, word 4k at MSBs.
REQ-014 SHALL have port rd_idx  input  4  buffer read index.
REQ-015 SHALL have port rd_data  output  128  buffered round key rd_idx, registered, 1-cycle latency.

Function
REQ-016 SHALL implement FIPS-197 expansion: Nk=4/6/8, Nr=10/12/14, total words 4(Nr+1)=44/52/60.
REQ-017 SHALL use FSM IDLE -> EXPAND -> FINISH -> IDLE; FINISH lasts exactly one cycle.
REQ-018 SHALL accept start in IDLE with legal key_size <= MAX_KEY_BITS: latch key/size, word counter i=0, rcon=0x01, enter EXPAND, busy=1 next cycle.
REQ-019 SHALL, on illegal or unsupported key_size with start in IDLE, stay IDLE and pulse err next cycle.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL produce exactly one word w[i] per EXPAND cycle: i<Nk copies key word i; else w[i-Nk] XOR temp.
REQ-022 SHALL form temp from w[i-1]: i mod Nk==0 -> SubWord(RotWord) XOR {rcon,24'h0} then rcon=xtime(rcon) (reduce 0x1B); Nk==8 and i mod Nk==4 -> SubWord only; else unchanged.
REQ-023 SHALL hold the last Nk words in an 8x32 sliding window; no full-schedule word array.
REQ-024 SHALL, once w[4k+3] is registered, present rk_out/rk_idx=k with rk_valid high in the following cycle; first at cycle 5 after acceptance, last (k=Nr) at cycle 4(Nr+1)+1.
REQ-025 SHALL enter FINISH after the last word: done=1 and busy=0 in the cycle after the last rk_valid.
REQ-026 SHALL write round key k to buffer entry k coincident with its rk_valid (RKEY_STORE=1).
REQ-027 SHALL return rd_data=0 for rd_idx > Nr of the last completed schedule or entries not yet written in the current run.
REQ-028 SHALL hold rk_out/rk_idx stable between rk_valid pulses; rk_valid, done, err never high in IDLE without cause.
REQ-029 SHALL allow start in the cycle immediately after done (back-to-back schedules).

Reset
REQ-030 SHALL on rst: state IDLE; busy, done, err, rk_valid=0; rk_idx=0; rk_out=0; rd_data=0; rcon=0x01; valid-entry count 0.
REQ-031 SHALL abort an in-progress expansion on rst with no done pulse; buffer contents need not clear but read as 0 (REQ-027).

Structure
REQ-032 SHALL take key-size encodings, NK/NR lookup, rcon polynomial 0x1B from shared package aes_pkg.
REQ-033 SHALL instantiate exactly one sub-module sub_word (four S-boxes, combinational, 32-bit).

Verification
REQ-034 SHALL cover AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> 11 rk_valid, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, done at cycle 46.
REQ-035 SHALL cover AES-192 key 000102..1617 -> 13 rk_valid, rk12=a4970a331a78dc09c418c271e3a41d5d.
REQ-036 SHALL cover AES-256 key 000102..1e1f -> 15 rk_valid, rk14=24fc79ccbf0979e9371ac23c6d68de36, then rd_idx=14 -> same value next cycle.
REQ-037 SHALL cover key_size=11 with start -> err pulse, busy stays 0; start while busy -> no effect on rk sequence.
REQ-038 SHALL cover rst asserted at cycle 20 of AES-128 -> all outputs 0 immediately, no done; new start then completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-size encodings, Nk/Nr lookup,
// GF(2^8) helpers and an S-box computed as a field inverse plus affine map.
package aes_pkg;

  typedef enum logic [1:0] {
    KS_128 = 2'b00,
    KS_192 = 2'b01,
    KS_256 = 2'b10,
    KS_BAD = 2'b11
  } key_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_FINISH
  } ks_state_e;

  localparam logic [7:0] RCON_POLY = 8'h1B;
  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic int key_bits(input key_size_e ks);
    case (ks)
      KS_128:  return 128;
      KS_192:  return 192;
      KS_256:  return 256;
      default: return 1024;
    endcase
  endfunction

  function automatic logic [3:0] nk_of(input key_size_e ks);
    case (ks)
      KS_192:  return 4'd6;
      KS_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_size_e ks);
    case (ks)
      KS_192:  return 4'd12;
      KS_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // inverse = a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as AES requires
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_schedule_gen_sub_word.sv
// SubWord: four parallel combinational S-box lookups on a 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end

endmodule

// File: rtl/key_schedule_gen.sv
// AES key expansion: one schedule word per cycle from an 8-word sliding window,
// streaming each round key and optionally buffering it for indexed read-back.
module key_schedule_gen
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter bit RKEY_STORE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              key_size,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    rk_valid,
  output logic [3:0]              rk_idx,
  output logic [127:0]            rk_out,
  input  logic [3:0]              rd_idx,
  output logic [127:0]            rd_data
);

  ks_state_e        state, state_nxt;
  key_size_e        ks_q;
  logic [255:0]     key_sr;
  logic [7:0][31:0] win;
  logic [5:0]       wcnt;
  logic [2:0]       j;
  logic [7:0]       rcon;
  logic             rk_pend;
  logic [3:0]       rk_cnt;
  logic [4:0]       vld_cnt;

  logic             accept, reject, size_ok, gen_word;
  logic [3:0]       nk, nr;
  logic [5:0]       total;
  logic [2:0]       back_idx;
  logic [31:0]      sw_in, sw_out, temp, w_new;
  logic [255:0]     key_align;

  assign nk        = nk_of(ks_q);
  assign nr        = nr_of(ks_q);
  assign total     = {nr, 2'b00} + 6'd4;
  assign back_idx  = 3'(nk - 4'd1);
  assign size_ok   = (key_size != KS_BAD) && (key_bits(key_size_e'(key_size)) <= MAX_KEY_BITS);
  assign key_align = 256'(key_in) << (256 - MAX_KEY_BITS);
  assign gen_word  = (state == ST_EXPAND) && (wcnt != total);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        if (size_ok) begin
          accept    = 1'b1;
          state_nxt = ST_EXPAND;
        end else begin
          reject    = 1'b1;
        end
      end
      // one drain cycle after the last word lets its round key go out first
      ST_EXPAND: if (wcnt == total) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // win[0] is w[i-1], win[m] is w[i-1-m]
  assign sw_in = (j == 3'd0) ? {win[0][23:0], win[0][31:24]} : win[0];

  sub_word u_sub_word (
    .din  (sw_in),
    .dout (sw_out)
  );

  always_comb begin
    temp = win[0];
    if (j == 3'd0)                       temp = sw_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && j == 3'd4)    temp = sw_out;
    w_new = ({2'b00, nk} > wcnt) ? key_sr[255 -: 32] : (win[back_idx] ^ temp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_q     <= KS_128;
      key_sr   <= '0;
      win      <= '0;
      wcnt     <= '0;
      j        <= '0;
      rcon     <= RCON_INIT;
      rk_pend  <= 1'b0;
      rk_cnt   <= '0;
      vld_cnt  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk_out   <= '0;
    end else begin
      done     <= (state == ST_FINISH);
      err      <= reject;
      rk_valid <= rk_pend;
      rk_pend  <= gen_word && (wcnt[1:0] == 2'b11);
      if (accept) begin
        ks_q    <= key_size_e'(key_size);
        key_sr  <= key_align;
        wcnt    <= '0;
        j       <= '0;
        rcon    <= RCON_INIT;
        rk_cnt  <= '0;
        vld_cnt <= '0;
      end
      if (gen_word) begin
        win    <= {win[6:0], w_new};
        key_sr <= key_sr << 32;
        wcnt   <= wcnt + 6'd1;
        j      <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
        if (j == 3'd0 && wcnt >= {2'b00, nk}) rcon <= xtime(rcon);
      end
      if (rk_pend) begin
        rk_out  <= win[3:0];
        rk_idx  <= rk_cnt;
        rk_cnt  <= rk_cnt + 4'd1;
        vld_cnt <= vld_cnt + 5'd1;
      end
    end
  end

  if (RKEY_STORE) begin : g_store
    logic [127:0] mem [16];
    logic [127:0] rd_q;

    always_ff @(posedge clk) begin
      if (rk_pend) mem[rk_cnt] <= win[3:0];
    end

    // entries beyond the written count read as zero, so stale data never leaks
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_q <= '0;
      else     rd_q <= ({1'b0, rd_idx} < vld_cnt) ? mem[rd_idx] : '0;
    end

    assign rd_data = rd_q;
  end else begin : g_nostore
    assign rd_data = '0;
  end

endmodule

// File: tb/tb_key_schedule_gen.sv
// Scoreboard bench for key_schedule_gen using FIPS-197 key-expansion vectors.
module tb_key_schedule_gen;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   key_size;
  logic [255:0] key_in;
  logic         busy, done, err, rk_valid;
  logic [3:0]   rk_idx, rd_idx;
  logic [127:0] rk_out, rd_data;

  always #5 clk = ~clk;

  key_schedule_gen #(.MAX_KEY_BITS(256), .RKEY_STORE(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .key_size(key_size), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .rk_valid(rk_valid), .rk_idx(rk_idx),
    .rk_out(rk_out), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] val;
    bit           chk_val;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0, n_fail = 0;
  int edge_cnt = 0, acc_edge = 0;
  int n_rk = 0, n_done = 0, first_rel = -1, last_rel = -1, done_rel = -1;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'h0123456789abcdeffedcba9876543210};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                   64'hffffffffffffffff};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK12_192 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] RK14_256 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] RK1_256  = 128'h101112131415161718191a1b1c1d1e1f;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (rk_valid) begin
      n_rk++;
      if (first_rel < 0) first_rel = edge_cnt - acc_edge;
      last_rel = edge_cnt - acc_edge;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rk_idx", 128'(rk_idx), 128'(e.idx));
        if (e.chk_val) chk($sformatf("rk%0d", e.idx), rk_out, e.val);
      end
    end
    if (done) begin
      n_done++;
      done_rel = edge_cnt - acc_edge;
    end
  end

  task automatic start_run(input logic [1:0] ks, input logic [255:0] key, input int nr,
                           input logic [127:0] rk1, input bit chk1, input logic [127:0] rkl);
    for (int k = 0; k <= nr; k++) begin
      exp_t e;
      e.idx     = 4'(k);
      e.chk_val = (k == 0) || (k == nr) || (k == 1 && chk1);
      e.val     = (k == 0) ? key[255 -: 128] : (k == 1) ? rk1 : rkl;
      sb_q.push_back(e);
    end
    n_rk = 0; n_done = 0; first_rel = -1; last_rel = -1; done_rel = -1;
    key_size = ks;
    key_in   = key;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    acc_edge = edge_cnt;
  endtask

  task automatic wait_done(input int nr);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done !== 1'b1 && t < 300);
    #1;
    chk("done_cyc", 128'(done_rel), 128'(4 * (nr + 1) + 2));
    chk("rk_count", 128'(n_rk), 128'(nr + 1));
    chk("first_rk_cyc", 128'(first_rel), 128'(5));
    chk("last_rk_cyc", 128'(last_rel), 128'(4 * (nr + 1) + 1));
    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    chk("busy_at_done", 128'(busy), 128'(0));
  endtask

  task automatic read_chk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    @(negedge clk);
    rd_idx = idx;
    @(negedge clk);
    chk(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_size = 2'b00; key_in = '0; rd_idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 128'({busy, done, err, rk_valid, rk_idx}), 128'(0));
    chk("rst_rk_out", rk_out, '0);
    chk("rst_rd_data", rd_data, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ctl", 128'({busy, done, err, rk_valid}), 128'(0));

    // illegal key size: err pulse, never busy
    key_size = 2'b11; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("err_pulse", 128'({err, busy}), 128'(2'b10));
    @(posedge clk); #1;
    chk("err_clear", 128'({err, busy}), 128'(0));

    // AES-128 with garbage in unused key LSBs
    start_run(2'b00, K128, 10, RK1_128, 1'b1, RK10_128);
    chk("busy_run", 128'(busy), 128'(1));
    wait_done(10);
    read_chk("rd_rk10", 4'd10, RK10_128);
    read_chk("rd_past_nr", 4'd11, '0);

    // AES-192 with a stray start mid-run, then AES-256 back-to-back
    start_run(2'b01, K192, 12, '0, 1'b0, RK12_192);
    repeat (10) @(negedge clk);
    key_size = 2'b00; key_in = K128; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_stray", 128'(busy), 128'(1));
    wait_done(12);
    start_run(2'b10, K256, 14, RK1_256, 1'b1, RK14_256);
    wait_done(14);
    read_chk("rd_rk14", 4'd14, RK14_256);
    read_chk("rd_idx15", 4'd15, '0);
    read_chk("rd_rk0", 4'd0, K256[255 -: 128]);

    // reset at cycle 20 of an AES-128 run
    start_run(2'b00, K128, 10, RK1_128, 1'b1, RK10_128);
    begin
      int t = 0;
      while ((edge_cnt - acc_edge) < 20 && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_ctl", 128'({busy, done, err, rk_valid, rk_idx}), 128'(0));
    chk("abort_rk_out", rk_out, '0);
    chk("abort_rd_data", rd_data, '0);
    sb_q.delete();
    n_rk = 0; n_done = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_no_done", 128'(n_done), 128'(0));
    chk("abort_no_rk", 128'(n_rk), 128'(0));
    read_chk("abort_rd0", 4'd0, '0);

    start_run(2'b00, K128, 10, RK1_128, 1'b1, RK10_128);
    wait_done(10);
    read_chk("rerun_rd10", 4'd10, RK10_128);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
    $finish;
  end

endmodule
